// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_pkg
// Brief    : Shared constants, FSM state type and baud-divider helper for the
//            memory-mapped UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package io_uart_pkg;

    // Bit positions inside the word address io_addr[15:2]
    localparam int unsigned c_DATA_WBIT   = 1;
    localparam int unsigned c_STATUS_WBIT = 2;

    // STATUS register bit positions
    localparam int unsigned c_STAT_FULL_BIT = 9;
    localparam int unsigned c_STAT_BUSY_BIT = 10;
    localparam int unsigned c_STAT_OVF_BIT  = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx_if
// Brief    : Core IO bus as seen by the UART transmitter (store strobe plus
//            combinational load data).
// Revision : 1.0 - initial release
// ============================================================================
interface io_uart_tx_if;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_wr;
    logic [31:0] io_rdata;

    modport master (
        output io_addr,
        output io_wdata,
        output io_wr,
        input  io_rdata
    );

    modport slave (
        input  io_addr,
        input  io_wdata,
        input  io_wr,
        output io_rdata
    );
endinterface
`default_nettype wire

// File: rtl/io_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx_sync_fifo
// Brief    : Single-clock show-ahead FIFO; dout always presents the head entry.
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);

    localparam int unsigned        c_AW       = $clog2(DEPTH);
    localparam logic [c_AW-1:0]    c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]      c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW:0]      c_CNT_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // Full is judged on the registered count, so a same-edge pop never rescues a push
    assign full      = (r_count == c_CNT_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with a transmit FIFO, DATA and
//            STATUS registers on the core IO bus.
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 10000000,
    parameter int unsigned BAUD_RATE   = 1000000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    io_uart_tx_if.slave      bus,
    output logic             uart_tx,
    output logic             tx_busy
);

    localparam int unsigned          c_DIV       = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned          c_CNT_W     = $clog2(c_DIV);
    localparam logic [c_CNT_W-1:0]   c_BAUD_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_BAUD_ONE  = c_CNT_W'(1);
    localparam int unsigned          c_FIFO_AW   = $clog2(FIFO_DEPTH);

    logic [13:0]          w_word;
    logic                 w_is_data;
    logic                 w_is_status;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [7:0]           w_dout;
    logic [c_FIFO_AW:0]   w_count;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_baud_end;
    logic                 w_unused;

    tx_state_t            r_state;
    logic [c_CNT_W-1:0]   r_baud;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_ovf;

    assign w_word      = bus.io_addr[15:2];
    assign w_is_data   = w_word[c_DATA_WBIT];
    assign w_is_status = w_word[c_STATUS_WBIT] & ~w_word[c_DATA_WBIT];
    assign w_push      = bus.io_wr & w_is_data;
    assign w_ovf_set   = w_push & w_full;
    assign w_ovf_clr   = bus.io_wr & w_is_status & bus.io_wdata[c_STAT_OVF_BIT];
    assign w_baud_end  = (r_baud == c_BAUD_LAST);

    // Head is consumed on leaving IDLE or at the end of a stop bit, giving gapless frames
    assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                               ((r_state == ST_STOP) & w_baud_end));

    assign w_unused = ^{bus.io_addr[31:16], bus.io_addr[1:0], w_word[13:3],
                        w_word[0], bus.io_wdata[31:12], bus.io_wdata[10:8]};

    io_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (bus.io_wdata[7:0]),
        .dout   (w_dout),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    assign uart_tx = r_tx;
    assign tx_busy = (w_count != '0) | (r_state != ST_IDLE);

    always_comb begin
        bus.io_rdata = '0;
        if (w_is_status) begin
            bus.io_rdata[c_STAT_FULL_BIT] = w_full;
            bus.io_rdata[c_STAT_BUSY_BIT] = tx_busy;
            bus.io_rdata[c_STAT_OVF_BIT]  = r_ovf;
        end
    end

    // Sticky overflow: a same-edge set beats a software clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_dout;
                        r_baud  <= '0;
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_idx   <= '0;
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 3'd1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_dout;
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_tx
// Brief    : Directed self-checking bench for io_uart_tx (DIV = 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    localparam logic [31:0] A_DATA = 32'h0040_0008;
    localparam logic [31:0] A_STAT = 32'h0040_0010;
    localparam logic [31:0] A_NONE = 32'h0040_0004;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic uart_tx;
    logic tx_busy;

    io_uart_tx_if bus ();

    io_uart_tx #(
        .CLK_FREQ_HZ (10000000),
        .BAUD_RATE   (1000000),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          t0       = 0;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Store on the next rising edge; returns at the following falling edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_wr    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.io_wr    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.io_addr = addr;
        #1;
        check(tag, bus.io_rdata, exp);
    endtask

    // Line model: frame j occupies cycles 1+FRAME*j .. FRAME*(j+1) relative to t0
    task automatic check_stream(input string tag);
        int         n;
        int         k;
        int         j;
        int         o;
        int         errs;
        logic       expb;
        logic [7:0] cur;
        logic [7:0] rx;
        n    = exp_q.size();
        errs = 0;
        rx   = '0;
        k    = cyc - t0;
        while (k <= FRAME * n) begin
            if (k >= 1) begin
                j   = (k - 1) / FRAME;
                o   = (k - 1) % FRAME;
                cur = exp_q[j];
                if (o < DIV)            expb = 1'b0;
                else if (o < 9 * DIV)   expb = cur[(o - DIV) / DIV];
                else                    expb = 1'b1;
                if (uart_tx !== expb) errs++;
                if (o >= DIV && o < 9 * DIV && (o % DIV) == DIV / 2)
                    rx[(o - DIV) / DIV] = uart_tx;
                if (k == FRAME * n)
                    check({tag, "_busy_last"}, {31'd0, tx_busy}, 32'd1);
                if (o == FRAME - 1) begin
                    check({tag, "_wave"}, errs, 32'd0);
                    check({tag, "_byte"}, {24'd0, rx}, {24'd0, cur});
                    errs = 0;
                    rx   = '0;
                end
            end
            @(negedge clk);
            k = cyc - t0;
        end
        check({tag, "_idle_tx"}, {31'd0, uart_tx}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        int bad;
        bus.io_addr  = '0;
        bus.io_wdata = '0;
        bus.io_wr    = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        rd("rst_status", A_STAT, 32'h0);

        // Single byte: start bit must not appear before the edge after the push
        exp_q = '{8'h55};
        wr(A_DATA, 32'h55);
        t0 = cyc;
        check("t1_tx_c0", {31'd0, uart_tx}, 32'd1);
        check("t1_busy_c0", {31'd0, tx_busy}, 32'd1);
        check_stream("t1");

        // Back-to-back frames with no gap
        exp_q = '{8'h41, 8'h42};
        wr(A_DATA, 32'h41);
        t0 = cyc;
        wr(A_DATA, 32'h42);
        check_stream("t2");

        // Overflow and sticky flag
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        wr(A_DATA, 32'hA0);
        t0 = cyc;
        for (int i = 1; i < 9; i++) wr(A_DATA, 32'hA0 + i);
        rd("ovf_full", A_STAT, 32'h600);
        wr(A_DATA, 32'hA9);
        rd("ovf_set", A_STAT, 32'hE00);
        wr(A_STAT, 32'h800);
        rd("ovf_clr", A_STAT, 32'h600);
        check_stream("t3");
        rd("ovf_done", A_STAT, 32'h0);

        // Decode
        rd("dec_stat", A_STAT, 32'h0);
        rd("dec_none", A_NONE, 32'h0);
        wr(A_NONE, 32'h55);
        bad = 0;
        repeat (20) begin
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("dec_nopush", bad, 32'd0);
        exp_q = '{8'h78};
        wr(A_DATA, 32'h1234_5678);
        t0 = cyc;
        check_stream("t5");

        // Reset during data bit 3 of 0xFF with two bytes queued
        wr(A_DATA, 32'hFF);
        t0 = cyc;
        wr(A_DATA, 32'h01);
        wr(A_DATA, 32'h02);
        while (cyc - t0 < 45) @(negedge clk);
        check("rst_mid_line", {31'd0, uart_tx}, 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
        rd("rst_mid_status", A_STAT, 32'h0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("rst_quiet", bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
